// File: rtl/dfu_boot_sequencer.sv
// rtl/dfu_boot_sequencer.sv - TinyDFU boot/reset sequencer with autoboot, image select and status LED
// Holds usb_dfu_core in reset, runs the autoboot countdown and drives SB_WARMBOOT plus the LED.
module dfu_boot_sequencer #(
  parameter int CLK_HZ          = 12000000,
  parameter int RESET_CYCLES    = 12000,
  parameter int BOOT_TIMEOUT_S  = 5,
  parameter int NUM_IMAGES      = 4,
  parameter int DEFAULT_IMAGE   = 1,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit LED_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
  input  logic       btn,
  output logic       core_reset,
  output logic [1:0] wb_image,
  output logic       wb_boot,
  output logic       autoboot_on,
  output logic       led
);

  localparam int TIMEOUT_CYC = CLK_HZ * BOOT_TIMEOUT_S;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    IMG_MAX    = 2'(NUM_IMAGES - 1);
  localparam logic [1:0]    IMG_DEF    = 2'(DEFAULT_IMAGE);

  typedef enum logic [1:0] {S_HOLD, S_ARMED, S_MANUAL, S_BOOT} state_e;

  state_e        state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [TW-1:0] timer_q;
  logic [DW-1:0] db_cnt_q;
  logic          btn_s1_q, btn_s2_q, db_state_q, press_q;
  logic [23:0]   lc_q;
  logic          core_reset_q, wb_boot_q, autoboot_q, led_q;
  logic [1:0]    wb_image_q;

  logic       boot_now, blink, busy, led_on, led_d;
  logic [4:0] pwm;
  logic [1:0] img_next;

  always_comb begin
    boot_now = 1'b0;
    if (state_q == S_ARMED || state_q == S_MANUAL)
      boot_now = dfu_detach || (state_q == S_ARMED && timer_q == '0);
    img_next = (wb_image_q == IMG_MAX) ? 2'd1 : wb_image_q + 2'd1;
  end

  always_comb begin
    blink  = (lc_q[22:20] == 3'd3) || (lc_q[22:20] == 3'd5);
    pwm    = lc_q[23] ? lc_q[22:18] : 5'd31 - lc_q[22:18];
    busy   = lc_q[17:13] >= pwm;
    led_on = 1'b0;
    case (state_q)
      S_HOLD: led_on = 1'b0;
      S_BOOT: led_on = 1'b1;
      default: begin
        // While armed, idle/dfuIDLE states flash the selected image number instead.
        if (state_q == S_ARMED && (dfu_state == 8'd0 || dfu_state == 8'd2))
          led_on = lc_q[22:20] < {1'b0, wb_image_q};
        else if (dfu_state == 8'd0)
          led_on = ~blink;
        else if (dfu_state == 8'd2)
          led_on = blink;
        else
          led_on = busy;
      end
    endcase
    led_d = led_on ^ LED_ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      timer_q      <= '0;
      db_cnt_q     <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      db_state_q   <= 1'b0;
      press_q      <= 1'b0;
      lc_q         <= '0;
      core_reset_q <= 1'b1;
      wb_boot_q    <= 1'b0;
      autoboot_q   <= 1'b0;
      wb_image_q   <= IMG_DEF;
      led_q        <= LED_ACTIVE_LOW;
    end else begin
      lc_q     <= lc_q + 24'd1;
      led_q    <= led_d;
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      press_q  <= 1'b0;
      if (btn_s2_q != db_state_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_state_q <= btn_s2_q;
          db_cnt_q   <= '0;
          press_q    <= btn_s2_q;
        end else begin
          db_cnt_q <= db_cnt_q + DW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end

      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            core_reset_q <= 1'b0;
            if (BOOT_TIMEOUT_S > 0) begin
              state_q    <= S_ARMED;
              autoboot_q <= 1'b1;
              timer_q    <= TIMER_LOAD;
            end else begin
              state_q <= S_MANUAL;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        S_ARMED, S_MANUAL: begin
          if (boot_now) begin
            state_q    <= S_BOOT;
            wb_boot_q  <= 1'b1;
            autoboot_q <= 1'b0;
          end else begin
            if (state_q == S_ARMED)
              timer_q <= press_q ? TIMER_LOAD : timer_q - TW'(1);
            if (press_q)
              wb_image_q <= img_next;
            if (state_q == S_ARMED && dfu_state > 8'd2) begin
              state_q    <= S_MANUAL;
              autoboot_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign wb_image    = wb_image_q;
  assign wb_boot     = wb_boot_q;
  assign autoboot_on = autoboot_q;
  assign led         = led_q;

endmodule

// File: tb/tb_dfu_boot_sequencer.sv
// tb/tb_dfu_boot_sequencer.sv - directed self-checking bench for dfu_boot_sequencer
// Inputs change and outputs are sampled on the falling edge; cyc counts rising edges.
module tb_dfu_boot_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] dfu_state = 8'd0;
  logic       dfu_detach = 1'b0;
  logic       btn = 1'b0;
  logic       core_reset, wb_boot, autoboot_on, led;
  logic [1:0] wb_image;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0, t_arm, t_boot, press_cyc;

  dfu_boot_sequencer #(
    .CLK_HZ(1000), .RESET_CYCLES(10), .BOOT_TIMEOUT_S(2), .NUM_IMAGES(4),
    .DEFAULT_IMAGE(1), .DEBOUNCE_CYCLES(4), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
    .btn(btn), .core_reset(core_reset), .wb_image(wb_image), .wb_boot(wb_boot),
    .autoboot_on(autoboot_on), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 1);
    check({tag, "_wb_boot"}, 32'(wb_boot), 0);
    check({tag, "_wb_image"}, 32'(wb_image), 1);
    check({tag, "_autoboot"}, 32'(autoboot_on), 0);
    check({tag, "_led"}, 32'(led), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_armed(input string tag);
    for (int i = 0; i < 50 && core_reset; i++) @(negedge clk);
    t_arm = cyc;
    check({tag, "_hold_len"}, t_arm - c0, 10);
    check({tag, "_autoboot_on"}, 32'(autoboot_on), 1);
  endtask

  task automatic wait_boot();
    for (int i = 0; i < 6000 && !wb_boot; i++) @(negedge clk);
    t_boot = cyc;
  endtask

  // Accepted press reaches the FSM on the 7th rising edge after btn goes high.
  task automatic do_press(input bit with_detach);
    @(negedge clk);
    btn = 1'b1;
    press_cyc = cyc;
    repeat (6) @(negedge clk);
    if (with_detach) dfu_detach = 1'b1;
    @(negedge clk);
    dfu_detach = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // Power-on reset, then HOLD ignores dfu_state and detach; idle autoboot.
    repeat (3) @(negedge clk);
    check_reset("por");
    dfu_state = 8'd3;
    release_reset();
    repeat (5) @(negedge clk);
    dfu_detach = 1'b1;
    @(negedge clk);
    dfu_detach = 1'b0;
    repeat (2) @(negedge clk);
    dfu_state = 8'd0;
    wait_armed("t1");
    check("t1_no_boot_from_hold", 32'(wb_boot), 0);
    @(negedge clk);
    check("t1_led_image_flash", 32'(led), 1);
    wait_boot();
    check("t1_autoboot_delay", t_boot - t_arm, 2000);
    check("t1_boot_image", 32'(wb_image), 1);
    check("t1_autoboot_off", 32'(autoboot_on), 0);
    @(negedge clk);
    check("t1_led_boot", 32'(led), 1);
    #2 reset_n = 1'b0;
    #1 check_reset("rst_in_boot");

    // Cancel by DFU activity, manual press, then detach.
    repeat (2) @(negedge clk);
    release_reset();
    wait_armed("t2");
    while (cyc < t_arm + 500) @(negedge clk);
    dfu_state = 8'd3;
    @(negedge clk);
    check("t2_cancel_autoboot", 32'(autoboot_on), 0);
    @(negedge clk);
    check("t2_led_busy", 32'(led), 0);
    do_press(1'b0);
    check("t2_manual_press", 32'(wb_image), 2);
    repeat (5000) @(negedge clk);
    check("t2_no_boot_after_cancel", 32'(wb_boot), 0);
    dfu_detach = 1'b1;
    @(negedge clk);
    dfu_detach = 1'b0;
    check("t2_detach_boot", 32'(wb_boot), 1);
    check("t2_image_kept", 32'(wb_image), 2);

    // Glitch rejection, image wrap, press restarts the countdown.
    @(negedge clk);
    dfu_state = 8'd0;
    reset_n = 1'b0;
    #1 check("t3_rst_image", 32'(wb_image), 1);
    repeat (2) @(negedge clk);
    release_reset();
    wait_armed("t3");
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_glitch", 32'(wb_image), 1);
    do_press(1'b0);
    check("t3_press1", 32'(wb_image), 2);
    do_press(1'b0);
    check("t3_press2", 32'(wb_image), 3);
    do_press(1'b0);
    check("t3_press3_wrap", 32'(wb_image), 1);
    wait_boot();
    check("t3_restart_delay", t_boot - press_cyc, 2007);
    do_press(1'b0);
    check("t3_boot_press_ignored", 32'(wb_image), 1);
    check("t3_boot_sticky", 32'(wb_boot), 1);

    // Async reset mid-ARMED, then press coincident with detach.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    wait_armed("t4");
    do_press(1'b0);
    check("t4_press", 32'(wb_image), 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset("rst_in_armed");
    release_reset();
    wait_armed("t4b");
    do_press(1'b1);
    check("t4_detach_wins", 32'(wb_boot), 1);
    check("t4_image_unchanged", 32'(wb_image), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
